// File: rtl/striping_if.sv
// Word stream into the striper and the two lane outputs plus status.
interface striping_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic [WIDTH-1:0] lane_0;
  logic             valid_0;
  logic [WIDTH-1:0] lane_1;
  logic             valid_1;
  logic [CNT_W-1:0] word_count;
  logic             next_lane;

  // Word source and lane consumer side
  modport master (
    output data_in,
    output valid_in,
    input  lane_0,
    input  valid_0,
    input  lane_1,
    input  valid_1,
    input  word_count,
    input  next_lane
  );

  // Striper side
  modport slave (
    input  data_in,
    input  valid_in,
    output lane_0,
    output valid_0,
    output lane_1,
    output valid_1,
    output word_count,
    output next_lane
  );
endinterface

// File: rtl/striping.sv
// Two-lane striper: accepted words alternate between lane_0 and lane_1 with
// one register stage of latency. Gaps hold the selector so that alternation
// resumes on the correct lane.
module striping #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input logic       clk_2f,
  input logic       reset,
  striping_if.slave bus
);

  typedef enum logic {
    SelL0 = 1'b0,
    SelL1 = 1'b1
  } sel_e;

  sel_e             state_q;
  logic [WIDTH-1:0] lane_0_q;
  logic [WIDTH-1:0] lane_1_q;
  logic             valid_0_q;
  logic             valid_1_q;
  logic [CNT_W-1:0] word_count_q;

  // Selector FSM with registered lane data, valids and accepted-word count
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q      <= SelL0;
      lane_0_q     <= '0;
      lane_1_q     <= '0;
      valid_0_q    <= 1'b0;
      valid_1_q    <= 1'b0;
      word_count_q <= '0;
    end else if (bus.valid_in) begin
      word_count_q <= word_count_q + CNT_W'(1);
      unique case (state_q)
        SelL0: begin
          lane_0_q  <= bus.data_in;
          valid_0_q <= 1'b1;
          valid_1_q <= 1'b0;
          state_q   <= SelL1;
        end
        SelL1: begin
          lane_1_q  <= bus.data_in;
          valid_1_q <= 1'b1;
          valid_0_q <= 1'b0;
          state_q   <= SelL0;
        end
        default: state_q <= SelL0;
      endcase
    end else begin
      // Idle cycle: lane data and selector hold, only the valids drop
      valid_0_q <= 1'b0;
      valid_1_q <= 1'b0;
    end
  end

  assign bus.lane_0     = lane_0_q;
  assign bus.lane_1     = lane_1_q;
  assign bus.valid_0    = valid_0_q;
  assign bus.valid_1    = valid_1_q;
  assign bus.word_count = word_count_q;
  assign bus.next_lane  = state_q;

endmodule
